// File: rtl/hmm_pkg.sv
// Shared constants and types for the Viterbi observation source and its integration code.
package hmm_pkg;
  localparam int OBS_W   = 2;
  localparam int STATE_W = 2;
  localparam int LEN_W   = 3;
  localparam int MAX_LEN = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GAP_W,
    S_SEND,
    S_WAIT_DONE
  } src_state_t;

  typedef logic [MAX_LEN*STATE_W-1:0] path_t;
endpackage

// File: rtl/obs_seq_buf.sv
// Observation sequence register file: append-only write pointer (count), indexed read, bulk clear.
module obs_seq_buf #(
  parameter int MAX_LEN = 7,
  parameter int LEN_W   = 3,
  parameter int OBS_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [OBS_W-1:0] i_wr_data,
  input  logic             i_clr,
  input  logic [LEN_W-1:0] i_rd_addr,
  output logic [OBS_W-1:0] o_rd_data,
  output logic [LEN_W-1:0] o_count,
  output logic             o_full
);
  logic [OBS_W-1:0] r_mem [MAX_LEN];
  logic [LEN_W-1:0] r_count;
  logic             w_wr;

  assign o_full  = (r_count == LEN_W'(MAX_LEN));
  assign o_count = r_count;
  assign w_wr    = i_wr_en && !o_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (w_wr) begin
      r_count <= r_count + LEN_W'(1);
    end
  end

  // Contents are intentionally not reset; only count qualifies them.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_count] <= i_wr_data;
    end
  end

  assign o_rd_data = (i_rd_addr < LEN_W'(MAX_LEN)) ? r_mem[i_rd_addr] : '0;
endmodule

// File: rtl/hmm_obs_source.sv
// Drives the Viterbi decoder start/obs_valid protocol from a host-filled buffer and captures the path.
module hmm_obs_source #(
  parameter int MAX_LEN = hmm_pkg::MAX_LEN,
  parameter int LEN_W   = hmm_pkg::LEN_W,
  parameter int OBS_W   = hmm_pkg::OBS_W,
  parameter int STATE_W = hmm_pkg::STATE_W,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [OBS_W-1:0]           wr_obs,
  input  logic                       go,
  output logic                       start,
  output logic [LEN_W-1:0]           length,
  output logic [OBS_W-1:0]           obs_in,
  output logic                       obs_valid,
  input  logic                       done,
  input  logic [MAX_LEN*STATE_W-1:0] path,
  output logic [MAX_LEN*STATE_W-1:0] path_out,
  output logic                       result_valid,
  output logic                       err,
  output logic                       busy,
  output logic [LEN_W-1:0]           count,
  output logic                       wr_full
);
  import hmm_pkg::*;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT);

  src_state_t                 r_state, w_next;
  logic [LEN_W-1:0]           r_k, r_length, w_rd_addr;
  logic [OBS_W-1:0]           r_obs_in, w_rd_data;
  logic [GW-1:0]              r_gap;
  logic [TW-1:0]              r_wait;
  logic [MAX_LEN*STATE_W-1:0] r_path_out;
  logic                       r_result_valid, r_err;
  logic                       w_wr_ok, w_done_hit, w_timeout, w_clr;

  assign w_wr_ok    = (r_state == S_IDLE) && wr_en && !go;
  assign w_done_hit = (r_state == S_WAIT_DONE) && done;
  assign w_timeout  = (r_state == S_WAIT_DONE) && !done && (r_wait == TO_LAST);
  assign w_clr      = w_done_hit || w_timeout;
  // r_k always names the next observation to send; IDLE pre-reads entry 0 for START.
  assign w_rd_addr  = (r_state == S_IDLE) ? '0 : r_k;

  obs_seq_buf #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .OBS_W   (OBS_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_ok),
    .i_wr_data (wr_obs),
    .i_clr     (w_clr),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data),
    .o_count   (count),
    .o_full    (wr_full)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (go && (count != '0)) w_next = S_START;
      S_START: begin
        if (r_length == LEN_W'(1)) w_next = S_WAIT_DONE;
        else if (GAP == 0)         w_next = S_SEND;
        else                       w_next = S_GAP_W;
      end
      S_GAP_W:     if (r_gap == GAP_LAST) w_next = S_SEND;
      S_SEND: begin
        if (r_k == r_length) w_next = S_WAIT_DONE;
        else if (GAP == 0)   w_next = S_SEND;
        else                 w_next = S_GAP_W;
      end
      S_WAIT_DONE: if (done || (r_wait == TO_LAST)) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    start     = (r_state == S_START);
    obs_valid = (r_state == S_SEND);
    busy      = (r_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k            <= '0;
      r_length       <= '0;
      r_obs_in       <= '0;
      r_gap          <= '0;
      r_wait         <= '0;
      r_path_out     <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      if ((r_state == S_IDLE) && go) begin
        if (count == '0) begin
          r_err <= 1'b1;
        end else begin
          r_length <= count;
          r_k      <= LEN_W'(1);
          r_obs_in <= w_rd_data;
        end
      end
      if (w_next == S_SEND) begin
        r_obs_in <= w_rd_data;
        r_k      <= r_k + LEN_W'(1);
      end
      r_gap  <= (r_state == S_GAP_W) ? r_gap + GW'(1) : '0;
      r_wait <= (r_state == S_WAIT_DONE) ? r_wait + TW'(1) : '0;
      if (w_done_hit) begin
        r_path_out     <= path;
        r_result_valid <= 1'b1;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign length       = r_length;
  assign obs_in       = r_obs_in;
  assign path_out     = r_path_out;
  assign result_valid = r_result_valid;
  assign err          = r_err;
endmodule

// File: tb/tb_hmm_obs_source.sv
// Directed bench for hmm_obs_source: instance a runs GAP=1/TIMEOUT=255, instance b runs GAP=0/TIMEOUT=16.
module tb_hmm_obs_source;
  import hmm_pkg::*;

  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic        a_wr_en = 0, a_go = 0, a_done = 0;
  logic [1:0]  a_wr_obs = 0;
  path_t       a_path = '0;
  logic        a_start, a_obs_valid, a_result_valid, a_err, a_busy, a_wr_full;
  logic [2:0]  a_length, a_count;
  logic [1:0]  a_obs_in;
  path_t       a_path_out;

  logic        b_wr_en = 0, b_go = 0, b_done = 0;
  logic [1:0]  b_wr_obs = 0;
  path_t       b_path = '0;
  logic        b_start, b_obs_valid, b_result_valid, b_err, b_busy, b_wr_full;
  logic [2:0]  b_length, b_count;
  logic [1:0]  b_obs_in;
  path_t       b_path_out;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  logic [1:0]   mdl_a[$];
  logic [1:0]   mdl_b[$];

  hmm_obs_source #(.GAP(1), .TIMEOUT(255)) u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_obs(a_wr_obs), .go(a_go),
    .start(a_start), .length(a_length), .obs_in(a_obs_in), .obs_valid(a_obs_valid),
    .done(a_done), .path(a_path), .path_out(a_path_out), .result_valid(a_result_valid),
    .err(a_err), .busy(a_busy), .count(a_count), .wr_full(a_wr_full)
  );

  hmm_obs_source #(.GAP(0), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_obs(b_wr_obs), .go(b_go),
    .start(b_start), .length(b_length), .obs_in(b_obs_in), .obs_valid(b_obs_valid),
    .done(b_done), .path(b_path), .path_out(b_path_out), .result_valid(b_result_valid),
    .err(b_err), .busy(b_busy), .count(b_count), .wr_full(b_wr_full)
  );

  // clock / cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected summary before 100us");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] mk(input int c, input logic st, input logic vl,
                                      input logic [2:0] len, input logic [1:0] o);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, 1'b0, st, vl, len, o};
  endfunction

  function automatic logic [31:0] a_all();
    return {4'd0, a_start, a_length, a_obs_in, a_obs_valid, a_path_out,
            a_result_valid, a_err, a_busy, a_count, a_wr_full};
  endfunction

  function automatic logic [31:0] b_all();
    return {4'd0, b_start, b_length, b_obs_in, b_obs_valid, b_path_out,
            b_result_valid, b_err, b_busy, b_count, b_wr_full};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every start/obs_valid strobe must match the next queued expectation, cycle included
  always @(negedge clk) begin
    if (a_start || a_obs_valid) begin
      if (exp_qa.size() == 0) check("a_strobe_extra", 32'(mk(cyc, a_start, a_obs_valid, a_length, a_obs_in)), 32'd0);
      else check("a_strobe", 32'(mk(cyc, a_start, a_obs_valid, a_length, a_obs_in)), 32'(exp_qa.pop_front()));
    end
    if (b_start || b_obs_valid) begin
      if (exp_qb.size() == 0) check("b_strobe_extra", 32'(mk(cyc, b_start, b_obs_valid, b_length, b_obs_in)), 32'd0);
      else check("b_strobe", 32'(mk(cyc, b_start, b_obs_valid, b_length, b_obs_in)), 32'(exp_qb.pop_front()));
    end
  end

  // driver tasks
  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wr(input int inst, input logic [1:0] v, input bit accept);
    @(negedge clk);
    if (inst == 0) begin
      a_wr_en = 1'b1; a_wr_obs = v;
      if (accept) mdl_a.push_back(v);
    end else begin
      b_wr_en = 1'b1; b_wr_obs = v;
      if (accept) mdl_b.push_back(v);
    end
    @(negedge clk);
    a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  task automatic launch(input int inst, input bit with_wr, output int m);
    int len;
    @(negedge clk);
    m = cyc;
    if (inst == 0) begin
      a_go = 1'b1;
      if (with_wr) begin a_wr_en = 1'b1; a_wr_obs = 2'd3; end
      len = mdl_a.size();
      for (int i = 0; i < len; i++)
        exp_qa.push_back(mk(m + 1 + i * 2, i == 0, i != 0, 3'(len), mdl_a[i]));
      mdl_a.delete();
    end else begin
      b_go = 1'b1;
      if (with_wr) begin b_wr_en = 1'b1; b_wr_obs = 2'd3; end
      len = mdl_b.size();
      for (int i = 0; i < len; i++)
        exp_qb.push_back(mk(m + 1 + i, i == 0, i != 0, 3'(len), mdl_b[i]));
      mdl_b.delete();
    end
    @(negedge clk);
    a_go = 1'b0; b_go = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  task automatic wait_flag(input int inst, input bit want_err, input int budget, output int seen);
    logic f;
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (inst == 0) f = want_err ? a_err : a_result_valid;
      else           f = want_err ? b_err : b_result_valid;
      if (f) begin
        seen = cyc;
        break;
      end
    end
  endtask

  initial begin
    int    m;
    int    seen;
    path_t p, p2;
    logic [1:0] v;

    // reset state
    repeat (3) @(negedge clk);
    check("a_reset_outputs", a_all(), 32'd0);
    check("b_reset_outputs", b_all(), 32'd0);
    rst = 1'b0;

    // nominal run 0,0,1,1,2 with a busy go and a busy write
    wr(0, 2'd0, 1); wr(0, 2'd0, 1); wr(0, 2'd1, 1); wr(0, 2'd1, 1); wr(0, 2'd2, 1);
    check("a_count_5", 32'(a_count), 32'd5);
    check("a_not_full_5", 32'(a_wr_full), 32'd0);
    launch(0, 0, m);
    wait_until(m + 3);
    a_go = 1'b1;
    @(negedge clk);
    a_go = 1'b0;
    wr(0, 2'd3, 0);
    check("a_busy_wr_drop", 32'(a_count), 32'd5);
    wait_until(m + 29);
    p = '0;
    p[5*2 +: 2] = 2'd0;
    p[2 +: 2] = 2'd0; p[4 +: 2] = 2'd1; p[6 +: 2] = 2'd1; p[8 +: 2] = 2'd2;
    a_done = 1'b1; a_path = p;
    wait_flag(0, 0, 15, seen);
    check("a_nom_rv_cycle", 32'(seen), 32'(m + 30));
    check("a_nom_path", 32'(a_path_out), 32'(p));
    check("a_nom_busy_low", 32'(a_busy), 32'd0);
    check("a_nom_count_clr", 32'(a_count), 32'd0);
    a_done = 1'b0;

    // length 1, with a write coincident with go
    wr(0, 2'd2, 1);
    launch(0, 1, m);
    check("a_go_wr_drop", 32'(a_count), 32'd1);
    check("a_len1_busy", 32'(a_busy), 32'd1);
    wait_until(m + 5);
    p = path_t'($urandom_range(0, 16383));
    a_done = 1'b1; a_path = p;
    wait_flag(0, 0, 10, seen);
    check("a_len1_rv_cycle", 32'(seen), 32'(m + 6));
    check("a_len1_path", 32'(a_path_out), 32'(p));
    a_done = 1'b0;

    // empty go
    launch(0, 0, m);
    check("a_empty_err", 32'(a_err), 32'd1);
    check("a_empty_busy", 32'(a_busy), 32'd0);
    @(negedge clk);
    check("a_empty_err_pulse", 32'(a_err), 32'd0);

    // buffer saturation at 7 and a full 7-entry run
    for (int i = 0; i < 9; i++) begin
      v = 2'($urandom_range(0, 3));
      wr(0, v, i < 7);
    end
    check("a_count_sat", 32'(a_count), 32'd7);
    check("a_full", 32'(a_wr_full), 32'd1);
    launch(0, 0, m);
    wait_until(m + 16);
    p = path_t'($urandom_range(0, 16383));
    a_done = 1'b1; a_path = p;
    wait_flag(0, 0, 10, seen);
    check("a_full_rv_cycle", 32'(seen), 32'(m + 17));
    check("a_full_path", 32'(a_path_out), 32'(p));
    check("a_full_count_clr", 32'(a_count), 32'd0);
    a_done = 1'b0;

    // reset while in GAP_W, then a clean run
    wr(0, 2'd3, 1); wr(0, 2'd1, 1); wr(0, 2'd2, 1);
    launch(0, 0, m);
    @(negedge clk);
    rst = 1'b1;
    exp_qa.delete();
    @(negedge clk);
    check("a_rst_mid_outputs", a_all(), 32'd0);
    rst = 1'b0;
    wr(0, 2'd1, 1); wr(0, 2'd3, 1);
    launch(0, 0, m);
    wait_until(m + 6);
    p = path_t'($urandom_range(0, 16383));
    a_done = 1'b1; a_path = p;
    wait_flag(0, 0, 10, seen);
    check("a_post_rst_rv_cycle", 32'(seen), 32'(m + 7));
    check("a_post_rst_path", 32'(a_path_out), 32'(p));
    a_done = 1'b0;

    // GAP=0 back-to-back run with an early done during SEND
    wr(1, 2'd2, 1); wr(1, 2'd0, 1); wr(1, 2'd3, 1);
    launch(1, 0, m);
    @(negedge clk);
    b_done = 1'b1; b_path = path_t'($urandom_range(0, 16383));
    @(negedge clk);
    check("b_early_done_no_rv", 32'(b_result_valid), 32'd0);
    check("b_early_done_busy", 32'(b_busy), 32'd1);
    b_done = 1'b0;
    p2 = path_t'($urandom_range(0, 16383));
    seen = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b_result_valid && seen < 0) seen = cyc;
      if (cyc == m + 8) begin b_done = 1'b1; b_path = p2; end
    end
    check("b_gap0_rv_cycle", 32'(seen), 32'(m + 9));
    check("b_gap0_path", 32'(b_path_out), 32'(p2));
    b_done = 1'b0;

    // timeout with done held low
    wr(1, 2'd1, 1); wr(1, 2'd2, 1);
    launch(1, 0, m);
    wait_flag(1, 1, 30, seen);
    check("b_timeout_err_cycle", 32'(seen), 32'(m + 20));
    check("b_timeout_path_kept", 32'(b_path_out), 32'(p2));
    check("b_timeout_no_rv", 32'(b_result_valid), 32'd0);
    check("b_timeout_busy", 32'(b_busy), 32'd0);
    check("b_timeout_count_clr", 32'(b_count), 32'd0);

    // final report
    repeat (2) @(negedge clk);
    check("a_queue_drained", 32'(exp_qa.size()), 32'd0);
    check("b_queue_drained", 32'(exp_qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
